// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: matrix width, FSM states, row priority helper.
package keypad_scanner_pkg;

    localparam int unsigned KeyWidth  = 4;
    localparam int unsigned CodeWidth = 4;

    typedef enum logic [1:0] {
        StScan     = 2'd0,
        StDebounce = 2'd1,
        StPressed  = 2'd2,
        StRelease  = 2'd3
    } state_e;

    // Index of the lowest-numbered low (pressed) row; 0 when none is low.
    function automatic logic [1:0] lowest_low_row(input logic [KeyWidth-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = KeyWidth - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV system clocks.
module scan_tick_gen #(
    parameter int unsigned DIV = 1000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic tick
);

    localparam int unsigned    DivW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(DIV - 1);

    logic [DivW-1:0] count;

    // Count 0..DIV-1 and wrap.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count <= '0;
        end else if (count == DivMax) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == DivMax);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-tick debounce of press and release.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_TICKS = 10
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [KeyWidth-1:0]  row_in,
    output logic [KeyWidth-1:0]  col_out,
    output logic                 IsPressed,
    output logic [CodeWidth-1:0] keyboard_data,
    output logic                 key_valid
);

    localparam int unsigned     CntW    = $clog2(DEBOUNCE_TICKS + 1);
    // A run is complete on the tick that brings the stable count up to DEBOUNCE_TICKS.
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_TICKS - 1);

    logic                tick;
    logic [KeyWidth-1:0] row_meta;
    logic [KeyWidth-1:0] row_s;
    state_e              state;
    logic [1:0]          col;
    logic [1:0]          hold_row;
    logic [CntW-1:0]     cnt;
    logic                run_done;
    logic                hold_low;

    scan_tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tick      (tick)
    );

    assign col_out  = ~(4'b0001 << col);
    assign run_done = (cnt >= CntLast);
    assign hold_low = ~row_s[hold_row];

    // Two-flop synchroniser for the asynchronous row inputs (idle high).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            row_meta <= '1;
            row_s    <= '1;
        end else begin
            row_meta <= row_in;
            row_s    <= row_meta;
        end
    end

    // Scan/debounce FSM with registered key outputs; decisions only on ticks.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= StScan;
            col           <= 2'd0;
            hold_row      <= 2'd0;
            cnt           <= '0;
            IsPressed     <= 1'b0;
            keyboard_data <= '0;
            key_valid     <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                unique case (state)
                    StScan: begin
                        if (&row_s) begin
                            col <= col + 2'd1;
                        end else begin
                            hold_row <= lowest_low_row(row_s);
                            cnt      <= CntW'(1);
                            state    <= StDebounce;
                        end
                    end
                    StDebounce: begin
                        if (hold_low) begin
                            cnt <= cnt + 1'b1;
                            if (run_done) begin
                                keyboard_data <= {hold_row, col};
                                IsPressed     <= 1'b1;
                                key_valid     <= 1'b1;
                                state         <= StPressed;
                            end
                        end else begin
                            // Bounce: rescan the same column from scratch.
                            cnt   <= '0;
                            state <= StScan;
                        end
                    end
                    StPressed: begin
                        if (!hold_low) begin
                            cnt   <= CntW'(1);
                            state <= StRelease;
                        end
                    end
                    StRelease: begin
                        if (!hold_low) begin
                            cnt <= cnt + 1'b1;
                            if (run_done) begin
                                IsPressed <= 1'b0;
                                col       <= col + 2'd1;
                                cnt       <= '0;
                                state     <= StScan;
                            end
                        end else begin
                            state <= StPressed;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: a keypad matrix model drives the rows from col_out and a
// tick-level behavioural model of the scan/debounce rules predicts the outputs.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DT       = 3;

    localparam int ModeScan = 0;
    localparam int ModeDeb  = 1;
    localparam int ModeHeld = 2;
    localparam int ModeRel  = 3;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       IsPressed;
    logic [3:0] keyboard_data;
    logic       key_valid;

    // keys[4*row + col] = 1 while that switch is closed.
    logic [15:0] keys = '0;

    int vectors    = 0;
    int miscompares = 0;
    int pulses     = 0;
    bit in_reset   = 1'b1;

    // Reference model state.
    int         m_mode, m_col, m_row, m_run, cyc, ticks;
    bit         m_pressed, m_valid;
    logic [3:0] m_data;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DT)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .row_in        (row_in),
        .col_out       (col_out),
        .IsPressed     (IsPressed),
        .keyboard_data (keyboard_data),
        .key_valid     (key_valid)
    );

    always #5 sys_clk = ~sys_clk;

    // Passive matrix: a closed switch pulls its row low when its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    function automatic bit key_down(int r, int c);
        return keys[4*r+c];
    endfunction

    task automatic model_reset();
        m_mode = ModeScan; m_col = 0; m_row = 0; m_run = 0;
        m_pressed = 0; m_valid = 0; m_data = 4'h0; cyc = 0;
    endtask

    // One clock edge of the behavioural model: rules applied once per scan slot.
    task automatic model_edge();
        int low;
        m_valid = 0;
        if (cyc % SCAN_DIV == SCAN_DIV - 1) begin
            ticks++;
            case (m_mode)
                ModeScan: begin
                    low = -1;
                    for (int r = 3; r >= 0; r--) if (key_down(r, m_col)) low = r;
                    if (low < 0) m_col = (m_col + 1) % 4;
                    else begin m_row = low; m_run = 1; m_mode = ModeDeb; end
                end
                ModeDeb: begin
                    if (key_down(m_row, m_col)) begin
                        m_run++;
                        if (m_run >= DT) begin
                            m_data = 4'(4 * m_row + m_col);
                            m_pressed = 1; m_valid = 1; m_mode = ModeHeld;
                        end
                    end else begin
                        m_run = 0; m_mode = ModeScan;
                    end
                end
                ModeHeld: begin
                    if (!key_down(m_row, m_col)) begin m_run = 1; m_mode = ModeRel; end
                end
                default: begin
                    if (!key_down(m_row, m_col)) begin
                        m_run++;
                        if (m_run >= DT) begin
                            m_pressed = 0; m_col = (m_col + 1) % 4; m_mode = ModeScan;
                        end
                    end else begin
                        m_mode = ModeHeld;
                    end
                end
            endcase
        end
        cyc++;
    endtask

    // Advance one clock; outputs are sampled at the falling edge.
    task automatic step();
        @(posedge sys_clk);
        if (!in_reset) model_edge();
        @(negedge sys_clk);
        if (key_valid === 1'b1) pulses++;
    endtask

    // Run until n more scan ticks have happened; returns just after a tick edge.
    task automatic run_ticks(int n);
        int target;
        int guard;
        target = ticks + n;
        guard  = 0;
        while (ticks < target && guard < n * SCAN_DIV + 8) begin
            step();
            guard++;
        end
    endtask

    task automatic wait_col(int c);
        int n;
        n = 0;
        do begin
            run_ticks(1);
            n++;
        end while (m_col != c && n < 16);
        vectors++;
        if (m_col != c) begin
            miscompares++;
            $display("FAIL wait_col: model column %0d never reached %0d", m_col, c);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        in_reset  = 1'b1;
        keys      = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({col_out, IsPressed, keyboard_data, key_valid} !== {4'b1110, 1'b0, 4'h0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_state: col=%b pressed=%b data=%h valid=%b, want 1110/0/0/0",
                         col_out, IsPressed, keyboard_data, key_valid);
            end
        end
        sys_rst_n = 1'b1;
        model_reset();
        ticks    = 0;
        in_reset = 1'b0;
    endtask

    task automatic test_column_walk();
        logic [3:0] walk [5];
        walk = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        for (int i = 0; i < 19; i++) begin
            step();
            vectors++;
            if (col_out !== walk[(i + 1) / 4] || IsPressed !== 1'b0 || key_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL column_walk[%0d]: col=%b pressed=%b valid=%b, want %b/0/0",
                         i, col_out, IsPressed, key_valid, walk[(i + 1) / 4]);
            end
        end
    endtask

    task automatic test_clean_press();
        wait_col(2);
        keys[6] = 1'b1;
        pulses  = 0;
        run_ticks(3);
        vectors++;
        if (pulses !== 1 || keyboard_data !== 4'h6 || IsPressed !== 1'b1 || col_out !== 4'b1011) begin
            miscompares++;
            $display("FAIL clean_press: pulses=%0d data=%h pressed=%b col=%b, want 1/6/1/1011",
                     pulses, keyboard_data, IsPressed, col_out);
        end
        run_ticks(2);
        vectors++;
        if (pulses !== 1 || col_out !== 4'b1011) begin
            miscompares++;
            $display("FAIL clean_hold: pulses=%0d col=%b, want 1/1011", pulses, col_out);
        end
        keys[6] = 1'b0;
        run_ticks(2);
        vectors++;
        if (IsPressed !== 1'b1) begin
            miscompares++;
            $display("FAIL release_early: pressed=%b, want 1", IsPressed);
        end
        run_ticks(1);
        vectors++;
        if (IsPressed !== 1'b0 || keyboard_data !== 4'h6 || col_out !== 4'b0111) begin
            miscompares++;
            $display("FAIL clean_release: pressed=%b data=%h col=%b, want 0/6/0111",
                     IsPressed, keyboard_data, col_out);
        end
    endtask

    task automatic test_bounce();
        wait_col(0);
        keys[8] = 1'b1;
        pulses  = 0;
        run_ticks(1);
        keys[8] = 1'b0;
        run_ticks(3);
        vectors++;
        if (pulses !== 0 || IsPressed !== 1'b0 || col_out !== 4'b1011 || keyboard_data !== 4'h6) begin
            miscompares++;
            $display("FAIL bounce: pulses=%0d pressed=%b col=%b data=%h, want 0/0/1011/6",
                     pulses, IsPressed, col_out, keyboard_data);
        end
    endtask

    task automatic test_two_rows();
        wait_col(1);
        keys[1]  = 1'b1;
        keys[13] = 1'b1;
        pulses   = 0;
        run_ticks(3);
        vectors++;
        if (pulses !== 1 || keyboard_data !== 4'h1 || IsPressed !== 1'b1) begin
            miscompares++;
            $display("FAIL two_rows: pulses=%0d data=%h pressed=%b, want 1/1/1",
                     pulses, keyboard_data, IsPressed);
        end
        keys[1]  = 1'b0;
        keys[13] = 1'b0;
        run_ticks(3);
        vectors++;
        if (IsPressed !== 1'b0 || col_out !== 4'b1011) begin
            miscompares++;
            $display("FAIL two_rows_release: pressed=%b col=%b, want 0/1011", IsPressed, col_out);
        end
    endtask

    task automatic test_release_glitch();
        wait_col(3);
        keys[11] = 1'b1;
        run_ticks(3);
        pulses   = 0;
        keys[11] = 1'b0;
        run_ticks(1);
        keys[11] = 1'b1;
        run_ticks(3);
        vectors++;
        if (IsPressed !== 1'b1 || pulses !== 0 || keyboard_data !== 4'hB || col_out !== 4'b0111) begin
            miscompares++;
            $display("FAIL release_glitch: pressed=%b pulses=%0d data=%h col=%b, want 1/0/b/0111",
                     IsPressed, pulses, keyboard_data, col_out);
        end
        keys[11] = 1'b0;
        run_ticks(3);
        vectors++;
        if (IsPressed !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_release: pressed=%b, want 0", IsPressed);
        end
    endtask

    task automatic test_reset_pressed();
        wait_col(0);
        keys[12] = 1'b1;
        run_ticks(3);
        vectors++;
        if (IsPressed !== 1'b1 || keyboard_data !== 4'hC) begin
            miscompares++;
            $display("FAIL pre_reset: pressed=%b data=%h, want 1/c", IsPressed, keyboard_data);
        end
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        in_reset  = 1'b1;
        #1;
        vectors++;
        if ({col_out, IsPressed, keyboard_data, key_valid} !== {4'b1110, 1'b0, 4'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_pressed: col=%b pressed=%b data=%h valid=%b, want 1110/0/0/0",
                     col_out, IsPressed, keyboard_data, key_valid);
        end
        step();
        step();
        sys_rst_n = 1'b1;
        model_reset();
        in_reset = 1'b0;
        pulses   = 0;
        run_ticks(1);
        vectors++;
        if (IsPressed !== 1'b0 || pulses !== 0) begin
            miscompares++;
            $display("FAIL redebounce_early: pressed=%b pulses=%0d, want 0/0", IsPressed, pulses);
        end
        run_ticks(2);
        vectors++;
        if (IsPressed !== 1'b1 || pulses !== 1 || keyboard_data !== 4'hC) begin
            miscompares++;
            $display("FAIL redebounce: pressed=%b pulses=%0d data=%h, want 1/1/c",
                     IsPressed, pulses, keyboard_data);
        end
        keys[12] = 1'b0;
        run_ticks(3);
    endtask

    // Random key activity changing only between scan slots, compared every cycle.
    task automatic test_random();
        int         target;
        int         nkeys;
        logic [3:0] exp_col;
        run_ticks(1);
        for (int it = 0; it < 60; it++) begin
            keys  = '0;
            nkeys = (($urandom_range(0, 1)) == 0) ? 0 : $urandom_range(1, 2);
            for (int k = 0; k < nkeys; k++) keys[$urandom_range(0, 15)] = 1'b1;
            target = ticks + $urandom_range(1, 6);
            while (ticks < target) begin
                step();
                exp_col = 4'hF ^ (4'b0001 << m_col);
                vectors++;
                if (col_out !== exp_col || IsPressed !== m_pressed || key_valid !== m_valid ||
                    keyboard_data !== m_data) begin
                    miscompares++;
                    $display("FAIL random[%0d]: col=%b pressed=%b valid=%b data=%h, want %b/%b/%b/%h",
                             it, col_out, IsPressed, key_valid, keyboard_data,
                             exp_col, m_pressed, m_valid, m_data);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        ticks = 0;
        test_reset();
        test_column_walk();
        test_clean_press();
        test_bounce();
        test_two_rows();
        test_release_glitch();
        test_reset_pressed();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
